sap1_loader: RTL and testbench

SAP1_LOADER -- requirements
Module: sap1_loader

---
 rtl/sap1_loader_if.sv | 26 ++
 rtl/sap1_loader.sv | 184 ++++++++++++++++++
 tb/tb_sap1_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_loader_if.sv
// Byte-source and SAP-1 front-panel signals of sap1_loader.
// master: loader side; slave: byte source / SAP-1 side.
interface sap1_loader_if;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       fp_clear;
    logic       fp_prog;
    logic       fp_write;
    logic [3:0] fp_adr;
    logic [7:0] fp_data;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, fp_clear, fp_prog, fp_write, fp_adr, fp_data, busy, done, err
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, fp_clear, fp_prog, fp_write, fp_adr, fp_data, busy, done, err
    );
endinterface

// File: rtl/sap1_loader.sv
// Loads a 16-byte program into a SAP-1 through its front panel, then releases it to run.
// Optional macro LOADER_CHECKSUM_EN adds a 17th checksum byte verified before release.
module sap1_loader #(
    parameter int unsigned WRITE_CYCLES = 2,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    sap1_loader_if.master bus
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StWaitByte, StWrite, StSettle, StRelease, StCheck
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle, StWaitByte, StWrite, StSettle, StRelease
    } state_t;
`endif

    state_t     r_state, w_state;
    logic [3:0] r_cnt,   w_cnt;
    logic [3:0] r_adr,   w_adr;
    logic [7:0] r_data,  w_data;
    logic       r_write, w_write;
    logic       r_clear, w_clear;
    logic       r_prog,  w_prog;
    logic       r_ready, w_ready;
    logic       r_busy,  w_busy;
    logic       r_done,  w_done;
`ifdef LOADER_CHECKSUM_EN
    logic       r_err,   w_err;
    logic [7:0] r_sum,   w_sum;
    logic [7:0] w_total;
`endif

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_adr   = r_adr;
        w_data  = r_data;
        w_write = r_write;
        w_clear = r_clear;
        w_prog  = r_prog;
        w_ready = r_ready;
        w_busy  = r_busy;
        w_done  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        w_err   = r_err;
        w_sum   = r_sum;
        w_total = r_sum + bus.in_data;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state = StWaitByte;
                    w_adr   = 4'd0;
                    w_clear = 1'b1;
                    w_prog  = 1'b1;
                    w_ready = 1'b1;
                    w_busy  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    w_err   = 1'b0;
                    w_sum   = 8'd0;
`endif
                end
            end
            StWaitByte: begin
                if (bus.in_valid && r_ready) begin
                    w_state = StWrite;
                    w_data  = bus.in_data;
                    w_write = 1'b1;
                    w_ready = 1'b0;
                    w_cnt   = 4'd0;
`ifdef LOADER_CHECKSUM_EN
                    w_sum   = w_total;
`endif
                end
            end
            StWrite: begin
                if (r_cnt == 4'(WRITE_CYCLES - 1)) begin
                    w_state = StSettle;
                    w_write = 1'b0;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
            StSettle: begin
                if (r_adr == 4'd15) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state = StCheck;
                    w_ready = 1'b1;
`else
                    w_state = StRelease;
                    w_prog  = 1'b0;
                    w_cnt   = 4'd0;
`endif
                end else begin
                    w_state = StWaitByte;
                    w_adr   = r_adr + 4'd1;
                    w_ready = 1'b1;
                end
            end
            StRelease: begin
                if (r_cnt == 4'(CLEAR_CYCLES - 1)) begin
                    w_state = StIdle;
                    w_clear = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (bus.in_valid && r_ready) begin
                    w_ready = 1'b0;
                    w_prog  = 1'b0;
                    if (w_total == 8'd0) begin
                        w_state = StRelease;
                        w_cnt   = 4'd0;
                    end else begin
                        // Failed load keeps the SAP-1 held in clear until the next start.
                        w_state = StIdle;
                        w_busy  = 1'b0;
                        w_err   = 1'b1;
                    end
                end
            end
`endif
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_adr   <= 4'd0;
            r_data  <= 8'd0;
            r_write <= 1'b0;
            r_clear <= 1'b0;
            r_prog  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_err   <= 1'b0;
            r_sum   <= 8'd0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_adr   <= w_adr;
            r_data  <= w_data;
            r_write <= w_write;
            r_clear <= w_clear;
            r_prog  <= w_prog;
            r_ready <= w_ready;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef LOADER_CHECKSUM_EN
            r_err   <= w_err;
            r_sum   <= w_sum;
`endif
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.fp_clear = r_clear;
    assign bus.fp_prog  = r_prog;
    assign bus.fp_write = r_write;
    assign bus.fp_adr   = r_adr;
    assign bus.fp_data  = r_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign bus.err      = r_err;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_sap1_loader.sv
// Bench for sap1_loader: transaction-level reference model compared every cycle,
// plus directed literal checks on load timing, stalls, ignored starts and reset.
module tb_sap1_loader;
    localparam int unsigned WC = 2;
    localparam int unsigned CC = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sap1_loader_if bus ();

    sap1_loader #(
        .WRITE_CYCLES(WC),
        .CLEAR_CYCLES(CC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bytes waiting to be offered by the byte source; head is driven on in_data.
    logic [7:0] q[$];

    // Reference model: what the panel must show, derived from load progress.
    bit         m_valid = 1'b0;
    logic       m_busy, m_ready, m_write, m_clear, m_prog, m_done, m_err;
    logic [3:0] m_adr;
    logic [7:0] m_data, m_sum;
    int         m_gap, m_rel, m_count;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            {m_busy, m_ready, m_write, m_clear, m_prog, m_done, m_err} = '0;
            m_adr = '0; m_data = '0; m_sum = '0;
            m_gap = 0; m_rel = 0; m_count = 0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1; m_ready = 1; m_clear = 1; m_prog = 1; m_err = 0;
                    m_adr = 0; m_count = 0; m_sum = 0;
                end
            end else if (m_ready) begin
                if (bus.in_valid) begin
                    m_ready = 0;
                    if (m_count < 16) begin
                        m_data = bus.in_data;
                        m_sum  = m_sum + bus.in_data;
                        m_write = 1;
                        m_gap = WC + 1;
                        m_count++;
                    end else begin
                        m_prog = 0;
                        if (8'(m_sum + bus.in_data) == 8'd0) m_rel = CC;
                        else begin m_err = 1; m_busy = 0; end
                    end
                    if (q.size() > 0) void'(q.pop_front());
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 1) m_write = 0;
                else if (m_gap == 0) begin
                    if (m_count == 16) begin
`ifdef LOADER_CHECKSUM_EN
                        m_ready = 1;
`else
                        m_prog = 0; m_rel = CC;
`endif
                    end else begin
                        m_adr = m_adr + 4'd1;
                        m_ready = 1;
                    end
                end
            end else if (m_rel > 0) begin
                m_rel--;
                if (m_rel == 0) begin m_clear = 0; m_busy = 0; m_done = 1; end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("in_ready", bus.in_ready, m_ready);
            check("fp_clear", bus.fp_clear, m_clear);
            check("fp_prog",  bus.fp_prog,  m_prog);
            check("fp_write", bus.fp_write, m_write);
            check("fp_adr",   bus.fp_adr,   m_adr);
            check("fp_data",  bus.fp_data,  m_data);
            check("busy",     bus.busy,     m_busy);
            check("done",     bus.done,     m_done);
            check("err",      bus.err,      m_err);
        end
    end

    // Pulse statistics for the literal checks.
    int pulses = 0, rel_cycles = 0, dones = 0, width = 0;
    bit prev_w = 1'b0;
    bit chk_eq = 1'b0;
    always @(negedge clk) begin
        if (bus.fp_write && !prev_w) begin
            pulses++;
            width = 1;
            if (chk_eq) check("data_eq_adr", bus.fp_data, {4'h0, bus.fp_adr});
        end else if (bus.fp_write) begin
            width++;
        end else if (prev_w && chk_eq) begin
            check("write_width", width, 2);
        end
        if (bus.busy && bus.fp_clear && !bus.fp_prog) rel_cycles++;
        if (bus.done) dones++;
        prev_w = bus.fp_write;
    end

    bit v_en = 1'b0;
    int v_pct = 100;
    int stall_idx = -1, stall_cnt = 0;
    int start_at = -1;

    task automatic drive();
        if (stall_cnt > 0 && m_ready && m_count == stall_idx) begin
            bus.in_valid = 1'b0;
            stall_cnt--;
            check("stall_ready", bus.in_ready, 1);
            check("stall_adr", bus.fp_adr, stall_idx);
            check("stall_write", bus.fp_write, 0);
            check("stall_clr_prog", {bus.fp_clear, bus.fp_prog}, 2'b11);
        end else begin
            bus.in_valid = v_en && (q.size() > 0) && ($urandom_range(0, 99) < v_pct);
        end
        bus.in_data = (q.size() > 0) ? q[0] : 8'($urandom);
    endtask

    task automatic step(input bit s);
        @(negedge clk);
        bus.start = s;
        drive();
    endtask

    task automatic clear_stats();
        pulses = 0; rel_cycles = 0; dones = 0;
    endtask

    task automatic run_load(input int max_cycles);
        bit fired;
        int i;
        fired = 0;
        step(1);
        for (i = 0; i < max_cycles; i++) begin
            if (start_at >= 0 && !fired && m_busy && m_adr == 4'(start_at)) begin
                fired = 1;
                step(1);
            end else begin
                step(0);
            end
            if (!m_busy) break;
        end
        if (i == max_cycles) check("load_timeout", 1, 0);
        step(0);
        step(0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        step(0);
        step(0);
        reset = 1'b0;
        check("rst_clear", bus.fp_clear, 0);
        check("rst_prog", bus.fp_prog, 0);
        check("rst_write", bus.fp_write, 0);
        check("rst_adr", bus.fp_adr, 0);
        check("rst_data", bus.fp_data, 0);
        check("rst_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);

        // Back-to-back 0x00..0x0F; valid offered in IDLE first must not be consumed.
        v_en = 1; v_pct = 100;
        for (int b = 0; b < 16; b++) q.push_back(8'(b));
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'h88);
`endif
        step(0); step(0); step(0);
        check("idle_not_consumed", q.size() > 0 ? q[0] : 8'hFF, 8'h00);
        clear_stats();
        chk_eq = 1;
        run_load(500);
        chk_eq = 0;
        check("ramp_pulses", pulses, 16);
        check("ramp_release_cycles", rel_cycles, 4);
        check("ramp_done", dones, 1);
        check("ramp_clear_after", bus.fp_clear, 0);

        // Stall before byte 3.
        for (int b = 0; b < 16; b++) q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        stall_idx = 3; stall_cnt = 10;
        clear_stats();
        run_load(500);
        check("stall_done_count", stall_cnt, 0);
        check("stall_pulses", pulses, 16);
        stall_idx = -1;

        // start pulsed at address 7 is ignored.
        for (int b = 0; b < 16; b++) q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        start_at = 7;
        clear_stats();
        run_load(500);
        start_at = -1;
        check("restart_pulses", pulses, 16);

        // Reset held 3 clocks mid-write at address 5.
        for (int b = 0; b < 16; b++) q.push_back(8'($urandom));
        step(1);
        for (int i = 0; i < 200; i++) begin
            if (m_adr == 4'd5 && m_write) break;
            step(0);
        end
        check("mid_write_reached", bus.fp_write && bus.fp_adr == 4'd5, 1);
        reset = 1'b1;
        step(0); step(0); step(0);
        reset = 1'b0;
        q.delete();
        check("mr_clear", bus.fp_clear, 0);
        check("mr_prog", bus.fp_prog, 0);
        check("mr_write", bus.fp_write, 0);
        check("mr_adr", bus.fp_adr, 0);
        check("mr_data", bus.fp_data, 0);
        check("mr_ready", bus.in_ready, 0);
        check("mr_busy", bus.busy, 0);

        // Reset wins over start.
        reset = 1'b1;
        step(1);
        step(0);
        reset = 1'b0;
        check("rst_vs_start_busy", bus.busy, 0);
        step(0);
        check("rst_vs_start_idle", bus.busy, 0);

`ifdef LOADER_CHECKSUM_EN
        for (int b = 0; b < 16; b++) q.push_back(8'h01);
        q.push_back(8'hF0);
        clear_stats();
        run_load(500);
        check("csum_ok_done", dones, 1);
        check("csum_ok_err", bus.err, 0);
        for (int b = 0; b < 16; b++) q.push_back(8'h01);
        q.push_back(8'h00);
        clear_stats();
        run_load(500);
        check("csum_bad_done", dones, 0);
        check("csum_bad_err", bus.err, 1);
        step(0); step(0); step(0);
        check("csum_bad_clear_held", bus.fp_clear, 1);
`endif

        // Random loads with random valid gaps and stray starts.
        for (int n = 0; n < 6; n++) begin
            logic [7:0] s;
            s = 8'h00;
            for (int b = 0; b < 16; b++) begin
                q.push_back(8'($urandom));
                s = s + q[q.size() - 1];
            end
`ifdef LOADER_CHECKSUM_EN
            q.push_back(($urandom_range(0, 1) == 1) ? 8'(-s) : 8'($urandom));
`endif
            v_pct = $urandom_range(30, 100);
            start_at = $urandom_range(0, 15);
            clear_stats();
            run_load(3000);
            check("rand_pulses", pulses, 16);
            q.delete();
        end
        start_at = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
